// File: rtl/uart_tx_cfg_if.sv
// Producer-side word handshake for the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_valid;
  logic                  Data_ready;

  modport master (
    output P_DATA,
    output Data_valid,
    input  Data_ready
  );

  modport slave (
    input  P_DATA,
    input  Data_valid,
    output Data_ready
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: baud divider, one-deep holding buffer,
// optional parity, one or two stop bits, frame-done pulse.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_cfg_if.slave         bus,
  input  logic                 PAR_EN,
  input  logic                 PAR_TYP,
  input  logic                 STOP2,
  input  logic [DIV_WIDTH-1:0] BAUD_DIV,
  output logic                 TX_OUT,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                state, state_n;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] shifter, shifter_n;
  logic                  hold_full;
  logic                  par_en_q, stop2_q, par_bit;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  bit_end, last_stop, load, accept, tx_n;

  assign bus.Data_ready = ~hold_full;
  assign accept         = bus.Data_valid & ~hold_full;
  assign busy           = (state != S_IDLE);

  // Next state, next shift value and next line level; a pending word
  // preempts the IDLE return at the end of the final stop bit.
  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    tx_n      = 1'b1;
    bit_end   = (baud_cnt == div_q);
    last_stop = bit_end && (((state == S_STOP1) && !stop2_q) || (state == S_STOP2));
    load      = hold_full && ((state == S_IDLE) || last_stop);
    case (state)
      S_IDLE:   state_n = S_IDLE;
      S_START:  if (bit_end) state_n = S_DATA;
      S_DATA:   if (bit_end && (bit_idx == LAST_IDX)) state_n = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: if (bit_end) state_n = S_STOP1;
      S_STOP1:  if (bit_end) state_n = stop2_q ? S_STOP2 : S_IDLE;
      S_STOP2:  if (bit_end) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (load) begin
      state_n   = S_START;
      shifter_n = hold;
    end else if ((state == S_DATA) && bit_end) begin
      shifter_n = shifter >> 1;
    end
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = shifter_n[0];
      S_PARITY: tx_n = par_bit;
      default:  tx_n = 1'b1;
    endcase
  end

  // Control state: FSM, counters, buffer flag, per-frame config and line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      hold_full <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      div_q     <= '0;
      par_bit   <= 1'b0;
      TX_OUT    <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state   <= state_n;
      TX_OUT  <= tx_n;
      tx_done <= last_stop;
      if ((state == S_IDLE) || bit_end) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + DIV_WIDTH'(1);
      if (load) begin
        bit_idx  <= '0;
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        div_q    <= BAUD_DIV;
        par_bit  <= PAR_TYP ? ~^hold : ^hold;
      end else if ((state == S_DATA) && bit_end) begin
        bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
      end
      if (accept)    hold_full <= 1'b1;
      else if (load) hold_full <= 1'b0;
    end
  end

  // Word storage: holding register and output shifter carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) hold <= bus.P_DATA;
    shifter <= shifter_n;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: table of single frames plus hand-written
// back-to-back, reset-abort and all-ones divider sequences.
module tb_uart_tx_cfg;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PAR_EN, PAR_TYP, STOP2;
  logic [15:0] BAUD_DIV;
  logic        TX_OUT, busy, tx_done;
  logic        s_tx, s_busy, s_done;

  int total_cnt = 0;
  int pass_cnt  = 0;

  uart_tx_cfg_if #(.DATA_WIDTH(8)) bus ();
  uart_tx_cfg_if #(.DATA_WIDTH(8)) sbus ();

  uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .STOP2(STOP2), .BAUD_DIV(BAUD_DIV), .TX_OUT(TX_OUT), .busy(busy), .tx_done(tx_done)
  );

  // Narrow-divider instance: BAUD_DIV all-ones exercises the counter wrap edge.
  uart_tx_cfg #(.DATA_WIDTH(8), .DIV_WIDTH(4)) dut_w (
    .CLK(CLK), .RST(RST), .bus(sbus), .PAR_EN(1'b0), .PAR_TYP(1'b0),
    .STOP2(1'b0), .BAUD_DIV(4'hF), .TX_OUT(s_tx), .busy(s_busy), .tx_done(s_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        par_en, par_typ, stop2;
    logic [11:0] bits;   // line level of each bit period, in send order
    int          n;      // bit periods in the frame
    logic        chg;    // rewrite config mid-frame with the nx_* values
    logic        nx_par_en, nx_par_typ, nx_stop2;
    logic [15:0] nx_div;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_frame(input int r, input vec_t v);
    int mism, side;
    PAR_EN   = v.par_en;
    PAR_TYP  = v.par_typ;
    STOP2    = v.stop2;
    BAUD_DIV = v.div;
    bus.P_DATA     = v.data;
    bus.Data_valid = 1'b1;
    check($sformatf("row%0d_ready_idle", r), bus.Data_ready, 1);
    @(negedge CLK);
    bus.Data_valid = 1'b0;
    check($sformatf("row%0d_ready_full", r), bus.Data_ready, 0);
    check($sformatf("row%0d_line_pre", r), TX_OUT, 1);
    @(negedge CLK);
    side = 0;
    for (int b = 0; b < v.n; b++) begin
      mism = 0;
      for (int c = 0; c <= int'(v.div); c++) begin
        if (TX_OUT !== v.bits[b]) mism++;
        if (busy !== 1'b1 || tx_done !== 1'b0) side++;
        if (v.chg && b == 1 && c == 0) begin
          PAR_EN   = v.nx_par_en;
          PAR_TYP  = v.nx_par_typ;
          STOP2    = v.nx_stop2;
          BAUD_DIV = v.nx_div;
        end
        @(negedge CLK);
      end
      check($sformatf("row%0d_bit%0d_mism", r, b), mism, 0);
    end
    check($sformatf("row%0d_busy_during", r), side, 0);
    check($sformatf("row%0d_done_pulse", r), tx_done, 1);
    check($sformatf("row%0d_busy_after", r), busy, 0);
    check($sformatf("row%0d_line_after", r), TX_OUT, 1);
    @(negedge CLK);
    check($sformatf("row%0d_done_clear", r), tx_done, 0);
  endtask

  initial begin
    int tx_err, rdy_err, bsy_err, done_cnt, done1, done2, err;
    logic [11:0] f1, f2;
    logic        e;

    vt[0] = '{8'hA5, 16'd0, 1'b0, 1'b0, 1'b0, 12'h34A, 10, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[1] = '{8'h07, 16'd3, 1'b1, 1'b0, 1'b0, 12'h60E, 11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[2] = '{8'h07, 16'd3, 1'b1, 1'b1, 1'b0, 12'h40E, 11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[3] = '{8'h55, 16'd1, 1'b0, 1'b0, 1'b0, 12'h2AA, 10, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0};
    vt[4] = '{8'h81, 16'd0, 1'b1, 1'b1, 1'b1, 12'hF02, 12, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[5] = '{8'h00, 16'd1, 1'b0, 1'b0, 1'b1, 12'h600, 11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[6] = '{8'hFF, 16'd0, 1'b1, 1'b1, 1'b1, 12'hFFE, 12, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vt[7] = '{8'h3C, 16'd2, 1'b1, 1'b0, 1'b0, 12'h478, 11, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};

    RST = 1'b1;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd0;
    bus.P_DATA = 8'h00;  bus.Data_valid = 1'b0;
    sbus.P_DATA = 8'h00; sbus.Data_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_ready", bus.Data_ready, 1);
    RST = 1'b0;
    @(negedge CLK);

    for (int r = 0; r < 8; r++) run_frame(r, vt[r]);

    // Back-to-back: second word buffered during first frame, no idle gap.
    PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b1; BAUD_DIV = 16'd1;
    bus.P_DATA = 8'h00; bus.Data_valid = 1'b1;
    @(negedge CLK);
    check("b2b_ready_t0", bus.Data_ready, 0);
    bus.P_DATA = 8'hFF;
    f1 = 12'hC00;
    f2 = 12'hDFE;
    tx_err = 0; rdy_err = 0; bsy_err = 0; done_cnt = 0; done1 = -1; done2 = -1;
    for (int t = 1; t <= 50; t++) begin
      @(negedge CLK);
      if (t == 1) check("b2b_ready_t1", bus.Data_ready, 1);
      if (t == 2) bus.Data_valid = 1'b0;
      if (t >= 2 && t <= 24 && bus.Data_ready !== 1'b0) rdy_err++;
      if (t <= 24)      e = f1[(t - 1) / 2];
      else if (t <= 48) e = f2[(t - 25) / 2];
      else              e = 1'b1;
      if (TX_OUT !== e) tx_err++;
      if (t <= 48 && busy !== 1'b1) bsy_err++;
      if (t == 49 && busy !== 1'b0) bsy_err++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done1 < 0) done1 = t; else done2 = t;
      end
    end
    check("b2b_line", tx_err, 0);
    check("b2b_ready_low", rdy_err, 0);
    check("b2b_busy", bsy_err, 0);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done1_t", done1, 25);
    check("b2b_done_gap", done2 - done1, 24);

    // Reset during DATA bit 3 with a second word buffered.
    PAR_EN = 1'b0; STOP2 = 1'b0; BAUD_DIV = 16'd2;
    bus.P_DATA = 8'hA5; bus.Data_valid = 1'b1;
    @(negedge CLK);
    bus.P_DATA = 8'h3C;
    @(negedge CLK);
    @(negedge CLK);
    bus.Data_valid = 1'b0;
    check("rab_buffered", bus.Data_ready, 0);
    repeat (12) @(negedge CLK);
    check("rab_pre_bit3", TX_OUT, 0);
    check("rab_pre_busy", busy, 1);
    RST = 1'b1;
    #1;
    check("rab_tx", TX_OUT, 1);
    check("rab_busy", busy, 0);
    check("rab_ready", bus.Data_ready, 1);
    check("rab_done", tx_done, 0);
    @(negedge CLK);
    RST = 1'b0;
    err = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) err++;
    end
    check("rab_quiet", err, 0);
    run_frame(8, vt[0]);

    // All-ones divider on the 4-bit-divider instance: 16 clocks per bit.
    sbus.P_DATA = 8'hA5; sbus.Data_valid = 1'b1;
    @(negedge CLK);
    sbus.Data_valid = 1'b0;
    @(negedge CLK);
    f1 = 12'h34A;
    err = 0; bsy_err = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (s_tx !== f1[b]) err++;
        if (s_busy !== 1'b1 || s_done !== 1'b0) bsy_err++;
        @(negedge CLK);
      end
    end
    check("wide_line", err, 0);
    check("wide_busy", bsy_err, 0);
    check("wide_done", s_done, 1);
    check("wide_idle", s_busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
